// File: rtl/queue_reader.sv
// Read-side master for the RAM-backed byte queue: pops a requested burst and
// presents it on a valid/ready stream through a 2-entry output buffer.
module queue_reader #(
    parameter int DW     = 8,
    parameter int CW     = 11,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rest_n,
    input  logic          start,
    input  logic [CW-1:0] len,
    output logic          q_en,
    output logic          q_rw,
    input  logic [DW-1:0] q_out,
    input  logic          q_empty,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] rd_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [DW-1:0]   head_q, head_d;
    logic [DW-1:0]   tail_q, tail_d;
    logic [1:0]      occ_q, occ_d;

    logic [1:0]      inflight;
    logic [2:0]      credit_use;
    logic            cap;
    logic            drain;
    logic            pop;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign q_en    = pop;
    assign q_rw    = 1'b0;
    assign busy    = (state_q == RUN) || (state_q == FLUSH);
    assign done    = (state_q == DONE);
    assign rd_cnt  = rd_cnt_q;

    // A byte drained this cycle frees its slot for a pop in the same cycle,
    // which is what sustains one byte per cycle with only two entries.
    always_comb begin
        inflight = 2'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {1'b0, pipe_q[i]};
        end
        cap        = pipe_q[RD_LAT-1];
        drain      = m_valid && m_ready;
        credit_use = {1'b0, occ_q} + {1'b0, inflight} - {2'b00, drain};
        pop        = (state_q == RUN) && (remaining_q != '0) && !q_empty
                     && (credit_use < 3'd2);
        pipe_d[0]  = pop;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_cnt_d    = rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = len;
                    rd_cnt_d    = '0;
                    state_d     = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop) begin
                    remaining_d = remaining_q - CW'(1);
                    rd_cnt_d    = rd_cnt_q + CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if ((inflight == 2'd0) && (occ_q == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Two-entry shift FIFO: head is always the oldest byte.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({cap, drain})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = q_out;
                end else begin
                    tail_d = q_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = q_out;
                end else begin
                    head_d = tail_q;
                    tail_d = q_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_cnt_q    <= '0;
            pipe_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_cnt_q    <= rd_cnt_d;
            pipe_q      <= pipe_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: behavioural 1 kB queue model, scoreboard of the
// bytes written into it, and a negedge stream monitor.
module tb_queue_reader;

    logic        clk = 1'b0;
    logic        rest_n;
    logic        start;
    logic [10:0] len;
    logic        q_en;
    logic        q_rw;
    logic [7:0]  q_out;
    logic        q_empty;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [10:0] rd_cnt;

    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr;
    logic [7:0]  mem [0:1023];
    logic [9:0]  wp, rp;
    logic [10:0] qcnt;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, first_x = -1, last_x = -1;
    int xfers = 0, qen_cnt = 0, done_cnt = 0, pend = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    queue_reader dut (
        .clk(clk), .rest_n(rest_n), .start(start), .len(len),
        .q_en(q_en), .q_rw(q_rw), .q_out(q_out), .q_empty(q_empty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .rd_cnt(rd_cnt)
    );

    assign q_empty = (qcnt == 11'd0);

    always @(posedge clk) begin
        if (clr) begin
            wp <= '0; rp <= '0; qcnt <= '0; q_out <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp <= wp + 10'd1;
            end
            if (q_en && !q_rw && qcnt != 11'd0) begin
                q_out <= mem[rp];
                rp <= rp + 10'd1;
            end
            qcnt <= qcnt + {10'd0, wr_en} - {10'd0, (q_en && !q_rw && qcnt != 11'd0)};
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rest_n) begin
            pend = 0;
            prev_stall = 1'b0;
        end else begin
            n_chk++;
            if (pend > 2) $display("FAIL credit: outstanding=%0d required<=2", pend);
            else n_pass++;
            if (prev_stall) begin
                n_chk++;
                if (m_valid !== 1'b1 || m_data !== prev_data)
                    $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
                else n_pass++;
            end
            if (q_en) begin
                qen_cnt++;
                n_chk++;
                if (q_empty !== 1'b0) $display("FAIL pop_when_empty: q_empty=%b required 0", q_empty);
                else n_pass++;
            end
            if (m_valid && m_ready) begin
                xfers++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                n_chk++;
                if (sb.size() == 0) $display("FAIL byte_unexpected: got %h with empty scoreboard", m_data);
                else begin
                    if (m_data !== sb[0]) $display("FAIL byte_order: got %h required %h", m_data, sb[0]);
                    else n_pass++;
                    void'(sb.pop_front());
                end
            end
            if (done) done_cnt++;
            pend = pend + (q_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
        sb.delete();
    endtask

    task automatic put(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b; sb.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1; len = 11'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0, input bit toggle);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            if (toggle) m_ready = ~m_ready;
            tick();
            k++;
        end
        n_chk++;
        if (done_cnt == d0) $display("FAIL done_timeout: no done within %0d cycles", budget);
        else n_pass++;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %0d required %0d", name, act, req);
        else n_pass++;
    endtask

    task automatic test_reset();
        rest_n = 1'b0;
        repeat (3) tick();
        chk("rst_q_en", int'(q_en), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_cnt", int'(rd_cnt), 0);
        chk("rst_q_rw", int'(q_rw), 0);
        rest_n = 1'b1;
        tick();
    endtask

    task automatic test_stream16();
        int d0, x0;
        do_clr();
        for (int i = 1; i <= 16; i++) put(8'(i));
        m_ready = 1'b1; qen_cnt = 0; first_x = -1; d0 = done_cnt; x0 = xfers;
        pulse_start(16);
        chk("s16_busy", int'(busy), 1);
        wait_done(100, d0, 1'b0);
        chk("s16_rd_cnt", int'(rd_cnt), 16);
        repeat (5) tick();
        chk("s16_qen", qen_cnt, 16);
        chk("s16_xfers", xfers - x0, 16);
        chk("s16_consecutive", last_x - first_x, 15);
        chk("s16_one_done", done_cnt - d0, 1);
        chk("s16_sb_empty", sb.size(), 0);
        chk("s16_idle", int'(busy), 0);
    endtask

    task automatic test_full1024();
        int d0, x0;
        do_clr();
        for (int i = 0; i < 1024; i++) put(8'(i));
        m_ready = 1'b1; qen_cnt = 0; d0 = done_cnt; x0 = xfers;
        pulse_start(1024);
        wait_done(1200, d0, 1'b0);
        chk("f1k_rd_cnt", int'(rd_cnt), 1024);
        repeat (5) tick();
        chk("f1k_qen", qen_cnt, 1024);
        chk("f1k_xfers", xfers - x0, 1024);
        chk("f1k_q_empty", int'(q_empty), 1);
        chk("f1k_one_done", done_cnt - d0, 1);
        chk("f1k_sb_empty", sb.size(), 0);
    endtask

    task automatic test_backpressure();
        int d0, x0;
        do_clr();
        for (int i = 0; i < 8; i++) put(8'hA0 + 8'(i));
        m_ready = 1'b1; qen_cnt = 0; d0 = done_cnt; x0 = xfers;
        pulse_start(8);
        wait_done(100, d0, 1'b1);
        m_ready = 1'b1;
        repeat (3) tick();
        chk("bp_qen", qen_cnt, 8);
        chk("bp_xfers", xfers - x0, 8);
        chk("bp_rd_cnt", int'(rd_cnt), 8);
        chk("bp_sb_empty", sb.size(), 0);
    endtask

    task automatic test_empty_stall();
        int d0, x0;
        do_clr();
        for (int i = 0; i < 3; i++) put(8'h30 + 8'(i));
        m_ready = 1'b1; qen_cnt = 0; d0 = done_cnt; x0 = xfers;
        pulse_start(5);
        repeat (20) tick();
        chk("es_xfers3", xfers - x0, 3);
        chk("es_busy", int'(busy), 1);
        chk("es_no_done", done_cnt - d0, 0);
        chk("es_q_en_idle", int'(q_en), 0);
        chk("es_rd_cnt3", int'(rd_cnt), 3);
        put(8'h33);
        put(8'h34);
        wait_done(50, d0, 1'b0);
        repeat (3) tick();
        chk("es_rd_cnt5", int'(rd_cnt), 5);
        chk("es_qen", qen_cnt, 5);
        chk("es_xfers5", xfers - x0, 5);
        chk("es_sb_empty", sb.size(), 0);
    endtask

    task automatic test_len0_and_ignore();
        int d0;
        do_clr();
        m_ready = 1'b1; qen_cnt = 0; d0 = done_cnt;
        pulse_start(0);
        wait_done(4, d0, 1'b0);
        repeat (3) tick();
        chk("l0_qen", qen_cnt, 0);
        chk("l0_one_done", done_cnt - d0, 1);
        chk("l0_rd_cnt", int'(rd_cnt), 0);
        for (int i = 0; i < 4; i++) put(8'hC0 + 8'(i));
        m_ready = 1'b0; qen_cnt = 0; d0 = done_cnt;
        pulse_start(4);
        repeat (3) tick();
        pulse_start(2);
        chk("ig_busy", int'(busy), 1);
        chk("ig_rd_cnt_credit", int'(rd_cnt), 2);
        m_ready = 1'b1;
        wait_done(50, d0, 1'b0);
        repeat (3) tick();
        chk("ig_rd_cnt", int'(rd_cnt), 4);
        chk("ig_qen", qen_cnt, 4);
        chk("ig_one_done", done_cnt - d0, 1);
        chk("ig_sb_empty", sb.size(), 0);
    endtask

    task automatic test_reset_midburst();
        int d0;
        do_clr();
        for (int i = 0; i < 16; i++) put(8'h50 + 8'(i));
        m_ready = 1'b0; d0 = done_cnt;
        pulse_start(16);
        repeat (3) tick();
        chk("mr_busy_before", int'(busy), 1);
        rest_n = 1'b0;
        #1;
        chk("mr_q_en", int'(q_en), 0);
        chk("mr_m_valid", int'(m_valid), 0);
        chk("mr_m_data", int'(m_data), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_rd_cnt", int'(rd_cnt), 0);
        repeat (3) tick();
        rest_n = 1'b1;
        sb.delete();
        m_ready = 1'b1;
        repeat (5) tick();
        chk("mr_no_done", done_cnt - d0, 0);
        chk("mr_idle", int'(busy), 0);
        chk("mr_no_pop", int'(q_en), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rest_n = 1'b0; start = 1'b0; len = '0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = '0; clr = 1'b1;
        tick();
        clr = 1'b0;
        test_reset();
        test_stream16();
        test_full1024();
        test_backpressure();
        test_empty_stall();
        test_len0_and_ignore();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
